dm_dmi_responder: RTL and testbench



---
 rtl/dm_dmi_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_dm_dmi_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_dmi_responder.sv
// rtl/dm_dmi_responder.sv - debug module register file behind the DMI trivial bus
module dm_dmi_responder #(
  parameter int unsigned DATACOUNT      = 1,
  parameter logic [31:0] HARTINFO_VALUE = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmi_start,
  output logic        dmi_finish,
  input  logic [1:0]  dmi_op,
  input  logic [6:0]  dmi_address,
  input  logic [31:0] dmi_wdata,
  output logic [31:0] dmi_rdata,
  output logic        haltreq,
  output logic        resumereq,
  output logic        ndmreset,
  input  logic        halted,
  input  logic        resumeack,
  output logic        ar_req,
  output logic        ar_write,
  output logic [15:0] ar_regno,
  output logic [31:0] ar_wdata,
  input  logic [31:0] ar_rdata,
  input  logic        ar_ack,
  input  logic        ar_err
);

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_HARTINFO   = 7'h12;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;
  localparam logic [3:0] DATACOUNT_W     = 4'(DATACOUNT);

  typedef enum logic {D_IDLE, D_RESP} dmi_state_e;
  typedef enum logic {A_IDLE, A_WAIT} ar_state_e;

  dmi_state_e  dmi_state_q, dmi_state_d;
  ar_state_e   ar_state_q, ar_state_d;
  logic [1:0]  op_q, op_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data0_q, data0_d;
  logic        haltreq_q, haltreq_d;
  logic        resumereq_q, resumereq_d;
  logic        ndmreset_q, ndmreset_d;
  logic        dmactive_q, dmactive_d;
  logic        resack_q, resack_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic        ar_write_q, ar_write_d;
  logic [15:0] ar_regno_q, ar_regno_d;
  logic [31:0] ar_wdata_q, ar_wdata_d;

  logic        busy;
  logic        wr_en;
  logic [31:0] rdata_mux;

  // busy is exactly "an access is outstanding on the hart port"
  assign busy  = (ar_state_q == A_WAIT);
  // the write side effect lands on the edge that closes the response cycle
  assign wr_en = (dmi_state_q == D_RESP) && (op_q == 2'd2);

  // Read multiplexer over the latched address
  always_comb begin
    rdata_mux = '0;
    case (addr_q)
      ADDR_DATA0:      rdata_mux = data0_q;
      ADDR_DMCONTROL:  rdata_mux = {haltreq_q, 1'b0, 28'b0, ndmreset_q, dmactive_q};
      ADDR_DMSTATUS:   rdata_mux = {14'b0, resack_q, resack_q, 4'b0, ~halted, ~halted,
                                    halted, halted, 1'b1, 3'b0, 4'd2};
      ADDR_HARTINFO:   rdata_mux = HARTINFO_VALUE;
      ADDR_ABSTRACTCS: rdata_mux = {3'b0, 5'd0, 11'b0, busy, 1'b0, cmderr_q, 4'b0, DATACOUNT_W};
      default:         rdata_mux = '0;
    endcase
  end

  // Next state of both FSMs and the register file; dmcontrol writes are applied last so a deactivation overrides everything
  always_comb begin
    dmi_state_d = dmi_state_q;
    ar_state_d  = ar_state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data0_d     = data0_q;
    haltreq_d   = haltreq_q;
    resumereq_d = resumereq_q;
    ndmreset_d  = ndmreset_q;
    dmactive_d  = dmactive_q;
    resack_d    = resack_q;
    cmderr_d    = cmderr_q;
    ar_write_d  = ar_write_q;
    ar_regno_d  = ar_regno_q;
    ar_wdata_d  = ar_wdata_q;

    case (dmi_state_q)
      D_IDLE: begin
        if (dmi_start) begin
          dmi_state_d = D_RESP;
          op_d        = dmi_op;
          addr_d      = dmi_address;
          wdata_d     = dmi_wdata;
        end
      end
      default: dmi_state_d = D_IDLE;
    endcase

    if (resumeack) begin
      resumereq_d = 1'b0;
      resack_d    = 1'b1;
    end

    if (busy && ar_ack) begin
      ar_state_d = A_IDLE;
      if (ar_err) begin
        cmderr_d = 3'd3;
      end else if (!ar_write_q) begin
        data0_d = ar_rdata;
      end
    end

    if (wr_en) begin
      if (addr_q == ADDR_DMCONTROL) begin
        dmactive_d = wdata_q[0];
        if (!wdata_q[0]) begin
          haltreq_d   = 1'b0;
          resumereq_d = 1'b0;
          ndmreset_d  = 1'b0;
          data0_d     = '0;
          cmderr_d    = '0;
          ar_state_d  = A_IDLE;
        end else begin
          haltreq_d  = wdata_q[31];
          ndmreset_d = wdata_q[1];
          if (wdata_q[30] && !wdata_q[31]) begin
            resumereq_d = 1'b1;
            resack_d    = 1'b0;
          end
        end
      end else if (dmactive_q) begin
        case (addr_q)
          ADDR_DATA0: begin
            if (busy) begin
              if (cmderr_q == 3'd0) cmderr_d = 3'd1;
            end else begin
              data0_d = wdata_q;
            end
          end
          ADDR_ABSTRACTCS: cmderr_d = cmderr_q & ~wdata_q[10:8];
          ADDR_COMMAND: begin
            if (busy) begin
              if (cmderr_q == 3'd0) cmderr_d = 3'd1;
            end else if (cmderr_q != 3'd0) begin
              cmderr_d = cmderr_q;
            end else if ((wdata_q[31:24] != 8'd0) || (wdata_q[22:20] != 3'd2) || wdata_q[18]) begin
              cmderr_d = 3'd2;
            end else if (!wdata_q[17]) begin
              cmderr_d = cmderr_q;
            end else if (!halted) begin
              cmderr_d = 3'd4;
            end else begin
              ar_state_d = A_WAIT;
              ar_write_d = wdata_q[16];
              ar_regno_d = wdata_q[15:0];
              ar_wdata_d = data0_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmi_state_q <= D_IDLE;
      ar_state_q  <= A_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data0_q     <= '0;
      haltreq_q   <= 1'b0;
      resumereq_q <= 1'b0;
      ndmreset_q  <= 1'b0;
      dmactive_q  <= 1'b0;
      resack_q    <= 1'b0;
      cmderr_q    <= '0;
      ar_write_q  <= 1'b0;
      ar_regno_q  <= '0;
      ar_wdata_q  <= '0;
    end else begin
      dmi_state_q <= dmi_state_d;
      ar_state_q  <= ar_state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data0_q     <= data0_d;
      haltreq_q   <= haltreq_d;
      resumereq_q <= resumereq_d;
      ndmreset_q  <= ndmreset_d;
      dmactive_q  <= dmactive_d;
      resack_q    <= resack_d;
      cmderr_q    <= cmderr_d;
      ar_write_q  <= ar_write_d;
      ar_regno_q  <= ar_regno_d;
      ar_wdata_q  <= ar_wdata_d;
    end
  end

  assign dmi_finish = (dmi_state_q == D_RESP);
  assign dmi_rdata  = (dmi_finish && (op_q == 2'd1)) ? rdata_mux : '0;
  assign haltreq    = haltreq_q;
  assign resumereq  = resumereq_q;
  assign ndmreset   = ndmreset_q;
  assign ar_req     = busy;
  assign ar_write   = ar_write_q;
  assign ar_regno   = ar_regno_q;
  assign ar_wdata   = ar_wdata_q;

endmodule

// File: tb/tb_dm_dmi_responder.sv
// tb/tb_dm_dmi_responder.sv - scoreboard bench for dm_dmi_responder against a register-level model
module tb_dm_dmi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmi_start = 1'b0;
  logic        dmi_finish;
  logic [1:0]  dmi_op = '0;
  logic [6:0]  dmi_address = '0;
  logic [31:0] dmi_wdata = '0;
  logic [31:0] dmi_rdata;
  logic        haltreq, resumereq, ndmreset;
  logic        halted = 1'b0;
  logic        resumeack = 1'b0;
  logic        ar_req, ar_write;
  logic [15:0] ar_regno;
  logic [31:0] ar_wdata;
  logic [31:0] ar_rdata = '0;
  logic        ar_ack = 1'b0;
  logic        ar_err = 1'b0;

  dm_dmi_responder dut (
    .clk(clk), .rst_n(rst_n),
    .dmi_start(dmi_start), .dmi_finish(dmi_finish), .dmi_op(dmi_op),
    .dmi_address(dmi_address), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
    .haltreq(haltreq), .resumereq(resumereq), .ndmreset(ndmreset),
    .halted(halted), .resumeack(resumeack),
    .ar_req(ar_req), .ar_write(ar_write), .ar_regno(ar_regno), .ar_wdata(ar_wdata),
    .ar_rdata(ar_rdata), .ar_ack(ar_ack), .ar_err(ar_err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  longint      cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    longint      cyc;
  } exp_t;
  exp_t expq[$];

  // reference model state: the debug module as seen from the debugger
  logic [31:0] m_data0;
  logic        m_haltreq, m_resumereq, m_ndmreset, m_dmactive, m_resack, m_busy;
  logic [2:0]  m_cmderr;
  logic        m_ar_write;
  logic [15:0] m_regno;
  logic [31:0] m_ar_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [6:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      7'h04: r = m_data0;
      7'h10: r = (32'(m_haltreq) << 31) | (32'(m_ndmreset) << 1) | 32'(m_dmactive);
      7'h11: begin
        r = 32'h0000_0082;
        r = r | (halted ? 32'h0000_0300 : 32'h0000_0C00);
        if (m_resack) r = r | 32'h0003_0000;
      end
      7'h12: r = 32'h0;
      7'h16: r = (32'(m_busy) << 12) | (32'(m_cmderr) << 8) | 32'd1;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic m_write(input logic [6:0] a, input logic [31:0] d);
    if (a == 7'h10) begin
      m_dmactive = d[0];
      if (!d[0]) begin
        m_haltreq = 0; m_resumereq = 0; m_ndmreset = 0;
        m_data0 = 0; m_cmderr = 0; m_busy = 0;
      end else begin
        m_haltreq  = d[31];
        m_ndmreset = d[1];
        if (d[30] && !d[31]) begin m_resumereq = 1; m_resack = 0; end
      end
    end else if (m_dmactive) begin
      if (a == 7'h04) begin
        if (m_busy) begin if (m_cmderr == 0) m_cmderr = 1; end
        else m_data0 = d;
      end else if (a == 7'h16) begin
        m_cmderr = m_cmderr & ~d[10:8];
      end else if (a == 7'h17) begin
        if (m_busy) begin
          if (m_cmderr == 0) m_cmderr = 1;
        end else if (m_cmderr != 0) begin
          // dropped
        end else if (d[31:24] != 0 || d[22:20] != 3'd2 || d[18]) begin
          m_cmderr = 2;
        end else if (!d[17]) begin
          // no transfer: nothing to do on the hart
        end else if (!halted) begin
          m_cmderr = 4;
        end else begin
          m_busy = 1; m_ar_write = d[16]; m_regno = d[15:0]; m_ar_wdata = m_data0;
        end
      end
    end
  endtask

  task automatic check_outs();
    check("dmi_finish_idle", 32'(dmi_finish), 32'd0);
    check("haltreq", 32'(haltreq), 32'(m_haltreq));
    check("resumereq", 32'(resumereq), 32'(m_resumereq));
    check("ndmreset", 32'(ndmreset), 32'(m_ndmreset));
    check("ar_req", 32'(ar_req), 32'(m_busy));
    if (m_busy) begin
      check("ar_write", 32'(ar_write), 32'(m_ar_write));
      check("ar_regno", 32'(ar_regno), 32'(m_regno));
      check("ar_wdata", ar_wdata, m_ar_wdata);
    end
  endtask

  // one DMI transaction; poke re-asserts dmi_start during the response cycle, which must be ignored
  task automatic dmi(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d, input bit poke);
    exp_t e;
    dmi_start = 1; dmi_op = op; dmi_address = a; dmi_wdata = d;
    e.rdata = (op == 2'd1) ? m_read(a) : 32'h0;
    e.cyc   = cyc + 1;
    expq.push_back(e);
    @(posedge clk); #1;
    if (poke) begin
      dmi_start = 1; dmi_op = 2'd2; dmi_address = 7'h10; dmi_wdata = 32'h0;
    end else begin
      dmi_start = 0;
    end
    @(posedge clk); #1;
    dmi_start = 0;
    if (op == 2'd2) m_write(a, d);
    check_outs();
  endtask

  task automatic rd(input logic [6:0] a);
    dmi(2'd1, a, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    dmi(2'd2, a, d, 1'b0);
  endtask

  task automatic hart_ack(input int dly, input logic err, input logic [31:0] rdv);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      check("ar_req_hold", 32'(ar_req), 32'(m_busy));
    end
    ar_ack = 1; ar_err = err; ar_rdata = rdv;
    @(posedge clk); #1;
    ar_ack = 0; ar_err = 0; ar_rdata = $urandom;
    if (m_busy) begin
      m_busy = 0;
      if (err) m_cmderr = 3;
      else if (!m_ar_write) m_data0 = rdv;
    end
    check_outs();
  endtask

  task automatic pulse_resumeack();
    resumeack = 1;
    @(posedge clk); #1;
    resumeack = 0;
    m_resumereq = 0; m_resack = 1;
    check_outs();
  endtask

  // monitor: every completion pulse is matched against the oldest expected response
  always @(negedge clk) begin
    if (rst_n && dmi_finish) begin
      if (expq.size() == 0) begin
        check("unexpected_finish", 32'(dmi_finish), 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("finish_latency", 32'(cyc), 32'(e.cyc));
        check("dmi_rdata", dmi_rdata, e.rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [6:0]  addrs [7];
    m_data0 = 0; m_haltreq = 0; m_resumereq = 0; m_ndmreset = 0; m_dmactive = 0;
    m_resack = 0; m_busy = 0; m_cmderr = 0; m_ar_write = 0; m_regno = 0; m_ar_wdata = 0;
    addrs[0] = 7'h04; addrs[1] = 7'h10; addrs[2] = 7'h11; addrs[3] = 7'h12;
    addrs[4] = 7'h16; addrs[5] = 7'h17; addrs[6] = 7'h05;

    repeat (4) @(posedge clk);
    #1;
    check("reset_finish", 32'(dmi_finish), 32'd0);
    check("reset_rdata", dmi_rdata, 32'd0);
    check("reset_ar_req", 32'(ar_req), 32'd0);
    check("reset_ar_regno", 32'(ar_regno), 32'd0);
    check_outs();
    rst_n = 1;
    @(posedge clk); #1;

    // dmstatus out of reset with a running hart
    rd(7'h11);
    rd(7'h16);
    // halt request and halted status
    wr(7'h10, 32'h8000_0001);
    halted = 1;
    @(posedge clk); #1;
    rd(7'h11);
    rd(7'h10);
    // write command with a 5-cycle ack
    wr(7'h04, 32'hDEAD_BEEF);
    wr(7'h17, 32'h0023_1001);
    hart_ack(5, 1'b0, 32'h0);
    rd(7'h16);
    // read command returns data into data0
    wr(7'h17, 32'h0022_1002);
    hart_ack(2, 1'b0, 32'h1234_5678);
    rd(7'h04);
    // faulting access sets cmderr=3, W1C clears it
    wr(7'h17, 32'h0022_1002);
    hart_ack(1, 1'b1, 32'hFFFF_0000);
    rd(7'h16);
    rd(7'h04);
    wr(7'h16, 32'h0000_0700);
    rd(7'h16);
    // command while busy, data0 write while busy
    wr(7'h17, 32'h0022_1003);
    wr(7'h17, 32'h0023_1004);
    wr(7'h04, 32'h5555_AAAA);
    rd(7'h16);
    hart_ack(0, 1'b0, 32'h0BAD_F00D);
    rd(7'h04);
    wr(7'h16, 32'h0000_0700);
    // bad aarsize, then not halted
    wr(7'h17, 32'h0032_1000);
    rd(7'h16);
    wr(7'h16, 32'h0000_0700);
    halted = 0;
    @(posedge clk); #1;
    wr(7'h17, 32'h0022_1000);
    rd(7'h16);
    wr(7'h16, 32'h0000_0700);
    // abort mid-command, late ack ignored, writes dropped while inactive
    halted = 1;
    wr(7'h04, 32'h0000_1111);
    wr(7'h17, 32'h0022_2000);
    wr(7'h10, 32'h0000_0000);
    hart_ack(1, 1'b0, 32'hCAFE_CAFE);
    rd(7'h04);
    rd(7'h16);
    wr(7'h04, 32'h7777_7777);
    rd(7'h04);
    wr(7'h10, 32'h0000_0001);
    wr(7'h04, 32'h7777_7777);
    rd(7'h04);
    // resume handshake
    wr(7'h10, 32'h4000_0003);
    rd(7'h11);
    pulse_resumeack();
    rd(7'h11);
    wr(7'h10, 32'hC000_0001);
    rd(7'h10);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          logic [1:0] op;
          op = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0) : 2'd1;
          dmi(op, addrs[$urandom_range(0, 6)], $urandom, 1'($urandom_range(0, 1)));
        end
        3: begin
          d = $urandom;
          d[0] = ($urandom_range(0, 7) != 0);
          dmi(2'd2, 7'h10, d, 1'($urandom_range(0, 1)));
        end
        4: dmi(2'd2, 7'h04, $urandom, 1'($urandom_range(0, 1)));
        5: dmi(2'd2, 7'h16, $urandom, 1'($urandom_range(0, 1)));
        6: begin
          d = $urandom;
          d[31:24] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
          d[22:20] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
          d[18]    = ($urandom_range(0, 7) == 0);
          d[17]    = ($urandom_range(0, 5) != 0);
          dmi(2'd2, 7'h17, d, 1'($urandom_range(0, 1)));
        end
        7: hart_ack($urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), $urandom);
        8: begin
          halted = ~halted;
          @(posedge clk); #1;
          check_outs();
        end
        default: pulse_resumeack();
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    check("pending_responses", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
